dir_rot_lut: RTL and testbench

Parametrised, writable successor to the fixed per-position direction ROMs used by the SIFT descriptor stage. It holds one table of 2^AW direction entries, DW bits each, loaded at run time through a streaming load port. It serves LANES lookups per cycle through a 2-stage valid/ready pipeline. Each result is rotated by a per-transaction orientation offset, modulo 2^DW. It sits between the gradient/patch address generator and the descriptor histogram accumulator, and replaces one hard-coded ROM per main orientation.

---
 rtl/dir_rot_lut.sv | 120 ++++++++++++
 tb/tb_dir_rot_lut.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_rot_lut.sv
// Writable direction lookup table with a streaming load port and a 2-stage
// valid/ready lookup pipeline that rotates each result by a per-request offset.
module dir_rot_lut #(
    parameter int AW    = 8,
    parameter int DW    = 5,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DW-1:0]         ld_data,
    output logic                  ld_done,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*AW-1:0]   in_addr,
    input  logic [DW-1:0]         in_offset,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_dir
);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_e;

    state_e                 state_q;
    logic [AW-1:0]          cnt_q;
    logic                   ld_done_q;
    logic [DW-1:0]          lut_q [2**AW];
    logic                   s1_valid_q;
    logic [LANES*AW-1:0]    s1_addr_q;
    logic [DW-1:0]          s1_off_q;
    logic                   out_valid_q;
    logic [LANES*DW-1:0]    out_dir_q;
    logic [LANES*DW-1:0]    out_dir_d;
    logic                   adv;
    logic                   wr_en;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = (state_q == RUN) && adv;
    assign busy      = (state_q == LOAD);
    assign ld_done   = ld_done_q;
    assign out_valid = out_valid_q;
    assign out_dir   = out_dir_q;

    // A restart pulse wins over a same-cycle data beat, so that beat is never written.
    assign wr_en = (state_q == LOAD) && ld_valid && !ld_start;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lut_q[cnt_q] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            cnt_q     <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (ld_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        cnt_q <= '0;
                    end else if (ld_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q   <= RUN;
                            ld_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Rotation is a plain DW-bit subtraction, so it wraps modulo the bin count.
    always_comb begin
        out_dir_d = out_dir_q;
        if (s1_valid_q) begin
            for (int i = 0; i < LANES; i++) begin
                out_dir_d[i*DW +: DW] = lut_q[s1_addr_q[i*AW +: AW]] - s1_off_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_off_q    <= '0;
            out_valid_q <= 1'b0;
            out_dir_q   <= '0;
        end else if (ld_start) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid && in_ready;
            s1_addr_q   <= in_addr;
            s1_off_q    <= in_offset;
            out_valid_q <= s1_valid_q;
            out_dir_q   <= out_dir_d;
        end
    end

endmodule

// File: tb/tb_dir_rot_lut.sv
// Self-checking bench for dir_rot_lut: directed scenarios with literal results
// plus randomized traffic scored against an array/queue model of the table.
module tb_dir_rot_lut;

    localparam int AW    = 8;
    localparam int DW    = 5;
    localparam int LANES = 2;
    localparam int DEPTH = 1 << AW;
    localparam int NBINS = 1 << DW;

    typedef logic [LANES*AW-1:0] addr_t;
    typedef logic [LANES*DW-1:0] dir_t;
    typedef logic [DW-1:0]       off_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  ld_start;
    logic  ld_valid;
    off_t  ld_data;
    logic  ld_done;
    logic  busy;
    logic  in_valid;
    logic  in_ready;
    addr_t in_addr;
    off_t  in_offset;
    logic  out_valid;
    logic  out_ready;
    dir_t  out_dir;

    int    compared   = 0;
    int    mismatched = 0;
    int    popped     = 0;
    bit    senderDone = 0;
    off_t  tbl [DEPTH];
    dir_t  expQ [$];

    always #5 clk = ~clk;

    dir_rot_lut #(.AW(AW), .DW(DW), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_offset (in_offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dir   (out_dir)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic off_t rot(input int t, input int o);
        int r;
        r = (t - o) % NBINS;
        if (r < 0) r += NBINS;
        return r[DW-1:0];
    endfunction

    function automatic dir_t expectedDir(input addr_t a, input off_t o);
        dir_t res;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            res[i*DW +: DW] = rot(int'(tbl[a[i*AW +: AW]]), int'(o));
        end
        return res;
    endfunction

    // Scoreboard: results appear in acceptance order; a held result is rechecked each stalled cycle.
    always @(negedge clk) begin
        dir_t e;
        if (!rst_n) begin
            expQ.delete();
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_output", 1, 0);
                end else begin
                    e = expQ[0];
                    for (int i = 0; i < LANES; i++) begin
                        checkOutput($sformatf("sb_lane%0d", i), int'(out_dir[i*DW +: DW]),
                                    int'(e[i*DW +: DW]));
                    end
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        popped++;
                    end
                end
            end
            if (ld_start) begin
                expQ.delete();
            end else if (in_valid && in_ready) begin
                expQ.push_back(expectedDir(in_addr, in_offset));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; returns one step after the accepting edge.
    task automatic applyStimulus(input addr_t a, input off_t o);
        bit acc;
        acc       = 0;
        in_valid  = 1'b1;
        in_addr   = a;
        in_offset = o;
        for (int n = 0; n < 100; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        checkOutput("accept", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic loadBody(input int mode, input bit gaps);
        int v;
        for (int k = 0; k < DEPTH; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                tick();
            end
            v = (mode == 0) ? (k % NBINS) : (mode == 1) ? 16 : int'($urandom_range(0, NBINS - 1));
            ld_valid = 1'b1;
            ld_data  = v[DW-1:0];
            tbl[k]   = v[DW-1:0];
            if (k == DEPTH - 1) begin
                checkOutput("ld_done_before_last", int'(ld_done), 0);
                checkOutput("busy_during_load", int'(busy), 1);
            end
            tick();
        end
        ld_valid = 1'b0;
        checkOutput("ld_done_pulse", int'(ld_done), 1);
        checkOutput("busy_after_load", int'(busy), 0);
        checkOutput("in_ready_after_load", int'(in_ready), 1);
        tick();
        checkOutput("ld_done_single", int'(ld_done), 0);
    endtask

    task automatic lookupLiteral(input string name, input addr_t a, input off_t o,
                                 input int e0, input int e1);
        out_ready = 1'b1;
        applyStimulus(a, o);
        checkOutput({name, "_latency"}, int'(out_valid), 0);
        tick();
        checkOutput({name, "_valid"}, int'(out_valid), 1);
        checkOutput({name, "_lane0"}, int'(out_dir[DW-1:0]), e0);
        checkOutput({name, "_lane1"}, int'(out_dir[2*DW-1:DW]), e1);
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            if (expQ.size() == 0) break;
            tick();
        end
        tick();
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        int   p0;
        dir_t held;
        rst_n     = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_offset = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_ld_done", int'(ld_done), 0);
        checkOutput("rst_out_dir", int'(out_dir), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] identity table load");
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        loadBody(0, 1'b0);

        $display("[TB] directed lookups");
        lookupLiteral("t2", {8'hF3, 8'h05}, 5'h00, 'h05, 'h13);
        lookupLiteral("t3", {8'h22, 8'h03}, 5'h07, 'h1C, 'h1B);
        lookupLiteral("wrapA", {8'h03, 8'h03}, 5'h05, 'h1E, 'h1E);
        lookupLiteral("wrapB", {8'hFF, 8'h1F}, 5'h1F, 'h00, 'h00);
        tick();

        $display("[TB] stream with stall");
        p0 = popped;
        senderDone = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(addr_t'($urandom), off_t'($urandom));
            end
            begin
                repeat (4) tick();
                out_ready = 1'b0;
                #2;
                held = out_dir;
                for (int s = 0; s < 3; s++) begin
                    if (s > 0) #2;
                    checkOutput("stall_in_ready", int'(in_ready), 0);
                    checkOutput("stall_out_valid", int'(out_valid), 1);
                    checkOutput("stall_hold", int'(out_dir), int'(held));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("stream_count", popped - p0, 8);

        $display("[TB] reload with requests in flight");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_addr   = {8'h10, 8'h20};
        in_offset = 5'h00;
        tick();
        in_addr  = {8'h30, 8'h40};
        ld_start = 1'b1;
        tick();
        in_valid = 1'b0;
        ld_start = 1'b0;
        checkOutput("flush_out_valid", int'(out_valid), 0);
        checkOutput("flush_busy", int'(busy), 1);
        checkOutput("flush_in_ready", int'(in_ready), 0);
        tick();
        checkOutput("flush_out_valid_2", int'(out_valid), 0);
        loadBody(1, 1'b0);
        lookupLiteral("reloadA", {8'hAB, 8'h00}, 5'h00, 'h10, 'h10);
        lookupLiteral("reloadB", {8'hFF, 8'h7E}, 5'h00, 'h10, 'h10);
        tick();

        $display("[TB] reset in the middle of a load");
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            ld_valid = 1'b1;
            ld_data  = off_t'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        checkOutput("midrst_out_dir", int'(out_dir), 0);
        repeat (2) tick();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_addr   = addr_t'($urandom);
        in_offset = off_t'($urandom);
        for (int n = 0; n < 4; n++) begin
            #1;
            checkOutput("empty_in_ready", int'(in_ready), 0);
            tick();
            checkOutput("empty_out_valid", int'(out_valid), 0);
        end
        in_valid = 1'b0;

        $display("[TB] restart inside load, random table");
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            ld_valid = 1'b1;
            ld_data  = off_t'($urandom);
            tick();
        end
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = off_t'($urandom);
        tick();
        ld_start = 1'b0;
        loadBody(2, 1'b1);

        $display("[TB] random traffic");
        senderDone = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        tick();
                    end
                    applyStimulus(addr_t'($urandom), off_t'($urandom));
                end
                senderDone = 1;
            end
            begin
                while (!senderDone) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
